// File: rtl/systolic_skew_buffer.sv
// systolic_skew_buffer
// Skew / deskew shift-register triangle for one edge of the systolic array.
// Lane i is delayed by i cycles (MODE=0, activation edge) or by
// N_LANES-1-i cycles (MODE=1, result edge). Invalid slots carry zero data
// so the array always sees zero-fill. A global enable stalls every stage,
// and a drain counter reports when the last accepted vector has fully left
// the triangle.
module systolic_skew_buffer #(
  parameter int N_LANES = 4,
  parameter int DATA_W  = 32,
  parameter int MODE    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    data_in   [N_LANES],
  output logic [DATA_W-1:0]    data_out  [N_LANES],
  output logic [N_LANES-1:0]   valid_out,
  output logic                 busy,
  output logic                 drain_done
);

  localparam int MAXD = N_LANES - 1;
  localparam int CW   = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  // Counter saturation value and the value one step before it.
  localparam logic [CW-1:0] CNT_MAX = CW'(MAXD);
  localparam logic [CW-1:0] CNT_PRE = CW'(MAXD - 1);

  if ((N_LANES < 2) || (N_LANES > 256)) begin : g_bad_n_lanes
    $error("systolic_skew_buffer: N_LANES must lie in 2..256");
  end

  logic [N_LANES-1:0] lane_busy_s;
  logic [CW-1:0]      cnt_r;
  logic               drain_done_r;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    localparam int D = (MODE == 0) ? i : (N_LANES - 1 - i);

    if (D == 0) begin : g_comb
      // Zero-delay lane: pass straight through, zero-filled when invalid.
      assign data_out[i]    = in_valid ? data_in[i] : '0;
      assign valid_out[i]   = in_valid & en;
      assign lane_busy_s[i] = 1'b0;
    end else begin : g_chain
      logic              v_r [D];
      logic [DATA_W-1:0] d_r [D];
      logic              any_v_s;

      // Shift chain: stage 0 captures the (zero-filled) input, later stages follow; all hold when en=0.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++) begin
            v_r[k] <= 1'b0;
            d_r[k] <= '0;
          end
        end else if (en) begin
          v_r[0] <= in_valid;
          d_r[0] <= in_valid ? data_in[i] : '0;
          for (int k = 1; k < D; k++) begin
            v_r[k] <= v_r[k-1];
            d_r[k] <= d_r[k-1];
          end
        end
      end

      // Lane occupancy: any valid word anywhere in this chain.
      always_comb begin
        any_v_s = 1'b0;
        for (int k = 0; k < D; k++) begin
          any_v_s = any_v_s | v_r[k];
        end
      end

      // Data holds through a stall, but valid is masked so the array never double-consumes.
      assign data_out[i]    = d_r[D-1];
      assign valid_out[i]   = en & v_r[D-1];
      assign lane_busy_s[i] = any_v_s;
    end
  end

  assign busy = |lane_busy_s;

  // Drain counter: cycles since the last accepted vector, saturating at MAXD (idle).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_MAX;
    end else if (en && in_valid) begin
      cnt_r <= '0;
    end else if (en && (cnt_r < CNT_MAX)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Drain pulse: fires on the single advance that takes the counter from MAXD-1 to MAXD.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_done_r <= 1'b0;
    end else begin
      drain_done_r <= en & ~in_valid & (cnt_r == CNT_PRE);
    end
  end

  assign drain_done = drain_done_r;

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Bench for systolic_skew_buffer: three configurations (4-lane skew,
// 4-lane deskew, 2-lane 8-bit) driven by directed scenarios followed by
// random traffic. The model counts enabled clock edges ("ticks"): a vector
// accepted at tick a shows on lane i at tick a+D(i); the drain pulse follows
// the edge that brings the tick to a+N_LANES with no accept in between.
module tb_systolic_skew_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          acc;
    int          due;
    logic [31:0] data;
  } item_t;

  for (genvar k = 0; k < 3; k++) begin : g_cfg
    localparam int NL = (k == 2) ? 2 : 4;
    localparam int DW = (k == 2) ? 8 : 32;
    localparam int MD = (k == 1) ? 1 : 0;

    logic          rst;
    logic          en;
    logic          in_valid;
    logic [DW-1:0] data_in  [NL];
    logic [DW-1:0] data_out [NL];
    logic [NL-1:0] valid_out;
    logic          busy;
    logic          drain_done;

    systolic_skew_buffer #(.N_LANES(NL), .DATA_W(DW), .MODE(MD)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .in_valid   (in_valid),
      .data_in    (data_in),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .busy       (busy),
      .drain_done (drain_done)
    );

    item_t         lq [NL][$];
    int            drain_q [$];
    int            tick     = 0;
    int            cyc      = 0;
    int            last_acc = -1;
    logic          p_rst    = 1'b1;
    logic          p_en     = 1'b0;
    logic          p_iv     = 1'b0;
    bit            done_f   = 1'b0;
    logic [DW-1:0] prev_d [NL];
    logic          prev_stall = 1'b0;

    function automatic int dly(input int i);
      return (MD == 0) ? i : (NL - 1 - i);
    endfunction

    // One cycle: account for the edge just taken, then drive new inputs
    // and push the expected lane emissions of an accepted vector.
    task automatic step(input logic r, input logic e, input logic v);
      item_t it;
      @(posedge clk);
      #1;
      cyc++;
      if (p_rst) begin
        for (int i = 0; i < NL; i++) lq[i].delete();
        drain_q.delete();
        last_acc = -1;
      end else if (p_en) begin
        if (p_iv) last_acc = tick;
        else if ((last_acc >= 0) && ((tick + 1 - last_acc) == NL)) drain_q.push_back(cyc);
        tick++;
      end
      rst      = r;
      en       = e;
      in_valid = v;
      for (int i = 0; i < NL; i++) data_in[i] = DW'($urandom);
      if (!r && e && v) begin
        for (int i = 0; i < NL; i++) begin
          it.acc  = tick;
          it.due  = tick + dly(i);
          it.data = 32'(data_in[i]);
          lq[i].push_back(it);
        end
      end
      p_rst = r;
      p_en  = e;
      p_iv  = v;
    endtask

    initial begin
      logic r, e, v;
      rst = 1'b1; en = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < NL; i++) data_in[i] = '0;
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      repeat (3) step(1'b0, 1'b1, 1'b0);
      // single vector
      step(1'b0, 1'b1, 1'b1);
      repeat (NL + 2) step(1'b0, 1'b1, 1'b0);
      // back-to-back pair: one drain pulse
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      repeat (NL + 2) step(1'b0, 1'b1, 1'b0);
      // two-cycle stall, with a vector offered (and dropped) during it
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      repeat (NL + 2) step(1'b0, 1'b1, 1'b0);
      // reset mid-flight
      step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b0);
      repeat (NL + 2) step(1'b0, 1'b1, 1'b0);
      // second accept restarts the drain count
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      repeat (NL + 2) step(1'b0, 1'b1, 1'b0);
      // random traffic
      repeat (600) begin
        r = ($urandom_range(0, 39) == 0);
        e = ($urandom_range(0, 4) != 0);
        v = r ? 1'b0 : 1'($urandom_range(0, 1));
        step(r, e, v);
      end
      repeat (NL + 2) step(1'b0, 1'b1, 1'b0);
      done_f = 1'b1;
    end

    // Monitor: compares every output against the scoreboard each cycle.
    always @(negedge clk) begin
      bit exp_b;
      bit exp_v;
      bit exp_dd;
      if (cyc >= 2) begin
        exp_b = 1'b0;
        for (int i = 0; i < NL; i++)
          for (int j = 0; j < lq[i].size(); j++)
            if (lq[i][j].acc < tick) exp_b = 1'b1;
        checks++;
        if (busy !== exp_b) begin
          errors++;
          $display("FAIL cfg%0d busy cyc %0d: got %b expected %b", k, cyc, busy, exp_b);
        end
        for (int i = 0; i < NL; i++) begin
          exp_v = en && (lq[i].size() > 0) && (lq[i][0].due == tick);
          checks++;
          if (valid_out[i] !== exp_v) begin
            errors++;
            $display("FAIL cfg%0d valid lane %0d cyc %0d: got %b expected %b", k, i, cyc, valid_out[i], exp_v);
          end else if (exp_v && (data_out[i] !== lq[i][0].data[DW-1:0])) begin
            errors++;
            $display("FAIL cfg%0d data lane %0d cyc %0d: got %h expected %h", k, i, cyc, data_out[i], lq[i][0].data[DW-1:0]);
          end else if (!exp_v && en && (data_out[i] !== '0)) begin
            errors++;
            $display("FAIL cfg%0d zerofill lane %0d cyc %0d: got %h expected 0", k, i, cyc, data_out[i]);
          end else if (!en && prev_stall && (dly(i) > 0) && (data_out[i] !== prev_d[i])) begin
            errors++;
            $display("FAIL cfg%0d hold lane %0d cyc %0d: got %h expected %h", k, i, cyc, data_out[i], prev_d[i]);
          end
          if (exp_v) void'(lq[i].pop_front());
          prev_d[i] = data_out[i];
        end
        exp_dd = (drain_q.size() > 0) && (drain_q[0] == cyc);
        if (exp_dd) void'(drain_q.pop_front());
        checks++;
        if (drain_done !== exp_dd) begin
          errors++;
          $display("FAIL cfg%0d drain_done cyc %0d: got %b expected %b", k, cyc, drain_done, exp_dd);
        end
        prev_stall = !en && !rst;
      end
    end
  end

  initial begin
    int w;
    w = 0;
    while (!(g_cfg[0].done_f && g_cfg[1].done_f && g_cfg[2].done_f) && (w < 20000)) begin
      @(posedge clk);
      w++;
    end
    checks++;
    if (w >= 20000) begin
      errors++;
      $display("FAIL timeout: stimulus still running after %0d cycles, limit 20000", w);
    end
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
